// File: rtl/led_mode_ctrl.sv
// Front-panel LED controller: debounces the mode and speed keys, steps a
// mode FSM and a speed level, and sequences the six-LED pattern generator.
module led_mode_ctrl #(
   parameter logic [31:0] CLK_DIV_BASE = 32'd2_500_000,
   parameter logic [19:0] DEBOUNCE_CYC = 20'd1_000_000
) (
   input  logic       clk_50m,
   input  logic       reset_n,
   input  logic       key_mode_n,
   input  logic       key_speed_n,
   output logic [5:0] led,
   output logic [2:0] mode,
   output logic [1:0] speed
);

   // state     | meaning
   // M_OFF     | all LEDs dark, steps ignored
   // M_FLOW_L  | single lit LED rotating towards led[5]
   // M_FLOW_R  | single lit LED rotating towards led[0]
   // M_PING    | single lit LED bouncing between led[0] and led[5]
   // M_BLINK   | all LEDs toggling together
   typedef enum logic [2:0] {
      M_OFF    = 3'd0,
      M_FLOW_L = 3'd1,
      M_FLOW_R = 3'd2,
      M_PING   = 3'd3,
      M_BLINK  = 3'd4
   } mode_t;

   // bit 0 = mode key, bit 1 = speed key
   logic [1:0]       sync1_q, sync1_d;
   logic [1:0]       sync2_q, sync2_d;
   logic [1:0]       stable_q, stable_d;
   logic [1:0]       press_q, press_d;
   logic [1:0][19:0] db_cnt_q, db_cnt_d;

   logic [31:0] base_cnt_q, base_cnt_d;
   logic [1:0]  sub_cnt_q, sub_cnt_d;
   logic        base_wrap;
   logic        step;
   logic        any_press;

   mode_t       mode_q, mode_d, mode_adv;
   logic [1:0]  speed_q, speed_d;
   logic [5:0]  led_q, led_d;
   logic [5:0]  ping_nxt;
   logic        dir_up_q, dir_up_d;

   // Synchronize the raw pins and debounce; a press is the accepted 1->0 edge.
   always_comb begin
      sync1_d  = {key_speed_n, key_mode_n};
      sync2_d  = sync1_q;
      stable_d = stable_q;
      press_d  = 2'b00;
      db_cnt_d = db_cnt_q;
      for (int i = 0; i < 2; i++) begin
         if (sync2_q[i] != stable_q[i]) begin
            if (db_cnt_q[i] == DEBOUNCE_CYC - 20'd1) begin
               stable_d[i] = sync2_q[i];
               db_cnt_d[i] = '0;
               press_d[i]  = ~sync2_q[i];
            end else begin
               db_cnt_d[i] = db_cnt_q[i] + 20'd1;
            end
         end else begin
            db_cnt_d[i] = '0;
         end
      end
   end

   // Key path registers; keys reset to the released level.
   always_ff @(posedge clk_50m or negedge reset_n) begin
      if (!reset_n) begin
         sync1_q  <= 2'b11;
         sync2_q  <= 2'b11;
         stable_q <= 2'b11;
         press_q  <= 2'b00;
         db_cnt_q <= '0;
      end else begin
         sync1_q  <= sync1_d;
         sync2_q  <= sync2_d;
         stable_q <= stable_d;
         press_q  <= press_d;
         db_cnt_q <= db_cnt_d;
      end
   end

   assign any_press = press_q[0] | press_q[1];
   assign base_wrap = (base_cnt_q == CLK_DIV_BASE - 32'd1);
   assign step      = base_wrap && (sub_cnt_q == 2'd3 - speed_q);

   // Step scheduler: a step every (4 - speed) base ticks, re-armed by any press.
   always_comb begin
      base_cnt_d = base_cnt_q + 32'd1;
      sub_cnt_d  = sub_cnt_q;
      if (any_press) begin
         base_cnt_d = '0;
         sub_cnt_d  = '0;
      end else if (base_wrap) begin
         base_cnt_d = '0;
         sub_cnt_d  = step ? 2'd0 : sub_cnt_q + 2'd1;
      end
   end

   // Mode FSM, speed level and pattern next-state; a press overrides a step.
   always_comb begin
      mode_d   = mode_q;
      speed_d  = speed_q;
      led_d    = led_q;
      dir_up_d = dir_up_q;
      ping_nxt = dir_up_q ? {led_q[4:0], 1'b0} : {1'b0, led_q[5:1]};

      case (mode_q)
         M_OFF:    mode_adv = M_FLOW_L;
         M_FLOW_L: mode_adv = M_FLOW_R;
         M_FLOW_R: mode_adv = M_PING;
         M_PING:   mode_adv = M_BLINK;
         default:  mode_adv = M_OFF;
      endcase

      if (press_q[1]) begin
         speed_d = speed_q + 2'd1;
      end

      if (mode_q > M_BLINK) begin
         mode_d   = M_OFF;
         led_d    = 6'b000000;
         dir_up_d = 1'b1;
      end else if (press_q[0]) begin
         mode_d   = mode_adv;
         dir_up_d = 1'b1;
         case (mode_adv)
            M_FLOW_L: led_d = 6'b000001;
            M_FLOW_R: led_d = 6'b100000;
            M_PING:   led_d = 6'b000001;
            default:  led_d = 6'b000000;
         endcase
      end else if (step && !press_q[1]) begin
         case (mode_q)
            M_FLOW_L: led_d = {led_q[4:0], led_q[5]};
            M_FLOW_R: led_d = {led_q[0], led_q[5:1]};
            M_PING: begin
               led_d = ping_nxt;
               if (ping_nxt == 6'b100000) begin
                  dir_up_d = 1'b0;
               end else if (ping_nxt == 6'b000001) begin
                  dir_up_d = 1'b1;
               end
            end
            M_BLINK:  led_d = ~led_q;
            default:  led_d = led_q;
         endcase
      end
   end

   // Scheduler, FSM and output registers.
   always_ff @(posedge clk_50m or negedge reset_n) begin
      if (!reset_n) begin
         base_cnt_q <= '0;
         sub_cnt_q  <= '0;
         mode_q     <= M_OFF;
         speed_q    <= 2'd0;
         led_q      <= 6'b000000;
         dir_up_q   <= 1'b1;
      end else begin
         base_cnt_q <= base_cnt_d;
         sub_cnt_q  <= sub_cnt_d;
         mode_q     <= mode_d;
         speed_q    <= speed_d;
         led_q      <= led_d;
         dir_up_q   <= dir_up_d;
      end
   end

   assign led   = led_q;
   assign mode  = mode_q;
   assign speed = speed_q;

endmodule

// File: tb/tb_led_mode_ctrl.sv
// Bench for led_mode_ctrl: a behavioural model predicts every change of
// {mode, speed, led} and a monitor matches the DUT's changes against it.
module tb_led_mode_ctrl;

   localparam int B = 4;
   localparam int D = 8;

   logic       clk_50m     = 1'b0;
   logic       reset_n     = 1'b1;
   logic       key_mode_n  = 1'b1;
   logic       key_speed_n = 1'b1;
   logic [5:0] led;
   logic [2:0] mode;
   logic [1:0] speed;

   led_mode_ctrl #(
      .CLK_DIV_BASE (32'd4),
      .DEBOUNCE_CYC (20'd8)
   ) dut (
      .clk_50m     (clk_50m),
      .reset_n     (reset_n),
      .key_mode_n  (key_mode_n),
      .key_speed_n (key_speed_n),
      .led         (led),
      .mode        (mode),
      .speed       (speed)
   );

   always #5 clk_50m = ~clk_50m;

   typedef struct {
      longint     stamp;
      logic [10:0] outs;
   } exp_t;

   exp_t        exp_q[$];
   int          checks = 0;
   int          errors = 0;
   logic [10:0] prev_out = '0;
   logic [10:0] last_exp = '0;
   bit          stim_done = 0;

   // Reference model: mode as 0..4, flow position, ping-pong table index,
   // blink phase, and an absolute cycle for the next step.
   int     m_mode = 0, m_speed = 0, m_pos = 0, m_idx = 0, m_phase = 0;
   longint next_step = -1;
   int     s1[2]   = '{1, 1};
   int     s2[2]   = '{1, 1};
   int     stab[2] = '{1, 1};
   int     run[2]  = '{0, 0};
   int     pend[2] = '{0, 0};
   int     pp_tab[10] = '{1, 2, 4, 8, 16, 32, 16, 8, 4, 2};

   function automatic logic [5:0] model_led();
      case (m_mode)
         1, 2:    return 6'(1 << m_pos);
         3:       return 6'(pp_tab[m_idx]);
         4:       return (m_phase != 0) ? 6'h3f : 6'h00;
         default: return 6'h00;
      endcase
   endfunction

   function automatic logic [10:0] model_outs();
      return {3'(m_mode), 2'(m_speed), model_led()};
   endfunction

   // Model advances on every clock edge and on reset; each predicted output
   // change is queued with the cycle at which the monitor should see it.
   always @(posedge clk_50m or negedge reset_n) begin : model
      longint stamp;
      int     pin[2];
      int     fire;
      exp_t   e;
      stamp = longint'($time) / 10;
      if (!reset_n) begin
         m_mode = 0; m_speed = 0; m_pos = 0; m_idx = 0; m_phase = 0;
         next_step = -1;
         for (int k = 0; k < 2; k++) begin
            s1[k] = 1; s2[k] = 1; stab[k] = 1; run[k] = 0; pend[k] = 0;
         end
      end else begin
         pin[0] = int'(key_mode_n);
         pin[1] = int'(key_speed_n);
         if (pend[0] == 1 || pend[1] == 1) begin
            if (pend[0] == 1) begin
               m_mode  = (m_mode + 1) % 5;
               m_pos   = (m_mode == 2) ? 5 : 0;
               m_idx   = 0;
               m_phase = 0;
            end
            if (pend[1] == 1) m_speed = (m_speed + 1) % 4;
            next_step = stamp + B * (4 - m_speed);
         end else if (stamp == next_step) begin
            next_step = stamp + B * (4 - m_speed);
            case (m_mode)
               1: m_pos = (m_pos + 1) % 6;
               2: m_pos = (m_pos + 5) % 6;
               3: m_idx = (m_idx + 1) % 10;
               4: m_phase = 1 - m_phase;
               default: ;
            endcase
         end
         for (int k = 0; k < 2; k++) begin
            fire = 0;
            if (s2[k] != stab[k]) begin
               if (run[k] == D - 1) begin
                  stab[k] = s2[k];
                  run[k]  = 0;
                  fire    = (s2[k] == 0) ? 1 : 0;
               end else begin
                  run[k]++;
               end
            end else begin
               run[k] = 0;
            end
            pend[k] = fire;
            s2[k]   = s1[k];
            s1[k]   = pin[k];
         end
      end
      if (model_outs() != last_exp) begin
         e.stamp = stamp;
         e.outs  = model_outs();
         exp_q.push_back(e);
         last_exp = model_outs();
      end
   end

   task automatic idle(input int n);
      repeat (n) @(negedge clk_50m);
   endtask

   task automatic set_key(input int k, input logic v);
      if (k == 0) key_mode_n = v;
      else        key_speed_n = v;
   endtask

   // mask bit 0 = mode key, bit 1 = speed key; both fall on the same edge
   task automatic press(input logic [1:0] mask);
      @(negedge clk_50m);
      if (mask[0]) key_mode_n = 1'b0;
      if (mask[1]) key_speed_n = 1'b0;
      idle(D + 6);
      key_mode_n  = 1'b1;
      key_speed_n = 1'b1;
      idle(D + 6);
   endtask

   // Bursts of short lows that must never be accepted.
   task automatic glitch(input int k);
      int n;
      n = int'($urandom_range(2, 5));
      for (int i = 0; i < n; i++) begin
         set_key(k, 1'b0);
         idle(int'($urandom_range(1, D - 1)));
         set_key(k, 1'b1);
         idle(int'($urandom_range(1, D - 1)));
      end
      idle(D + 2);
   endtask

   task automatic check_val(input string name, input int got, input int want);
      checks++;
      if (got != want) begin
         errors++;
         $display("FAIL %s got=%0d want=%0d", name, got, want);
      end
   endtask

   initial begin
      #1 reset_n = 1'b0;
      repeat (3) @(negedge clk_50m);
      #2 reset_n = 1'b1;
      @(negedge clk_50m);
      check_val("reset_mode", int'(mode), 0);
      check_val("reset_speed", int'(speed), 0);
      check_val("reset_led", int'(led), 0);
      prev_out = {mode, speed, led};

      fork
         begin : stimulus
            int r;
            idle(200);
            for (int i = 0; i < 10; i++) begin
               key_mode_n = ~key_mode_n;
               idle(3);
            end
            key_mode_n = 1'b0;
            idle(D + 6);
            key_mode_n = 1'b1;
            idle(D + 6);
            idle(120);
            for (int i = 0; i < 3; i++) press(2'b10);
            idle(40);
            press(2'b10);
            idle(70);
            press(2'b01);
            press(2'b01);
            idle(12 * 16 + 10);
            press(2'b01);
            idle(70);
            for (int i = 0; i < 30; i++) begin
               r = int'($urandom_range(0, 9));
               if (r <= 2)      press(2'b01);
               else if (r <= 4) press(2'b10);
               else if (r == 5) press(2'b11);
               else if (r <= 7) glitch(int'($urandom_range(0, 1)));
               else             idle(int'($urandom_range(0, 80)));
            end
            for (int i = 0; i < 40; i++) begin
               if (m_mode == 2 && m_speed == 1) break;
               if (m_mode != 2) press(2'b01);
               else             press(2'b10);
            end
            check_val("setup_flow_r_mode", m_mode, 2);
            check_val("setup_flow_r_speed", m_speed, 1);
            press(2'b11);
            idle(30);
            @(negedge clk_50m);
            #2 reset_n = 1'b0;
            #1;
            check_val("midrun_reset_mode", int'(mode), 0);
            check_val("midrun_reset_speed", int'(speed), 0);
            check_val("midrun_reset_led", int'(led), 0);
            idle(3);
            #2 reset_n = 1'b1;
            press(2'b01);
            press(2'b10);
            idle(60);
            stim_done = 1;
         end
         begin : monitor
            exp_t        e;
            logic [10:0] cur;
            longint      st;
            while (!stim_done) begin
               @(negedge clk_50m);
               st  = (longint'($time) - 1) / 10;
               cur = {mode, speed, led};
               if (cur !== prev_out) begin
                  checks++;
                  if (exp_q.size() == 0) begin
                     errors++;
                     $display("FAIL unexpected_change cyc=%0d got mode=%0d speed=%0d led=%b, none predicted",
                              st, cur[10:8], cur[7:6], cur[5:0]);
                  end else begin
                     e = exp_q.pop_front();
                     if (e.outs !== cur || e.stamp != st) begin
                        errors++;
                        $display("FAIL out_change got mode=%0d speed=%0d led=%b cyc=%0d want mode=%0d speed=%0d led=%b cyc=%0d",
                                 cur[10:8], cur[7:6], cur[5:0], st,
                                 e.outs[10:8], e.outs[7:6], e.outs[5:0], e.stamp);
                     end
                  end
                  prev_out = cur;
               end else if (exp_q.size() > 0 && exp_q[0].stamp < st) begin
                  checks++;
                  errors++;
                  e = exp_q.pop_front();
                  $display("FAIL missed_change got mode=%0d speed=%0d led=%b cyc=%0d want mode=%0d speed=%0d led=%b cyc=%0d",
                           cur[10:8], cur[7:6], cur[5:0], st,
                           e.outs[10:8], e.outs[7:6], e.outs[5:0], e.stamp);
               end
            end
         end
      join

      check_val("pending_predictions", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/led_mode_ctrl.md
# led_mode_ctrl

Front-panel controller for the six board LEDs. It debounces two push-buttons, runs a mode state machine and a speed selector, and sequences the LED pattern generator: left flow, right flow, ping-pong, blink or off. It sits between the raw key pins and the `led[5:0]` pins, and replaces a free-running flow block in the top level.

## Interface
- `CLK_DIV_BASE`, default 32'd2_500_000: cycles per base tick (50 ms at 50 MHz).
- `DEBOUNCE_CYC`, default 20'd1_000_000: consecutive stable cycles required to accept a key level (20 ms).
- `clk_50m`  in  1  system clock, 50 MHz.
- `reset_n`  in  1  reset, asynchronous, active-low.
- `key_mode_n`  in  1  mode button, active-low, asynchronous pin.
- `key_speed_n`  in  1  speed button, active-low, asynchronous pin.
- `led`  out  6  LED drive, registered, 1 = on.
- `mode`  out  3  current mode, registered: 0 OFF, 1 FLOW_L, 2 FLOW_R, 3 PING_PONG, 4 BLINK.
- `speed`  out  2  current speed level 0..3, registered.

## Operation
- **Key path, per key:**
  - 2-FF synchronizer, then debounce.
  - The debounce counter runs while the synced level differs from the stable level and clears when they are equal.
  - When the counter reaches DEBOUNCE_CYC-1 with the levels still different, the stable level takes the synced level and the counter clears.
  - Press event: a one-cycle pulse when the stable level goes 1→0. Release generates nothing.
- **Mode FSM:** OFF→FLOW_L→FLOW_R→PING_PONG→BLINK→OFF, advancing one state per mode press. Encodings 5–7 are unreachable and recover to OFF on the next cycle.
- **Speed:** each speed press increments `speed` modulo 4 (3→0).
- **Step scheduler:**
  - `base_cnt` counts 0..CLK_DIV_BASE-1 and wraps.
  - `sub_cnt` increments on each base wrap.
  - A step fires on the base wrap where `sub_cnt` == 3-speed; `sub_cnt` then returns to 0.
  - Step period = CLK_DIV_BASE×(4-speed) cycles.
  - Both counters clear on any mode or speed press.
- **Entry pattern,** loaded on mode change:
  - FLOW_L: 000001
  - FLOW_R: 100000
  - PING_PONG: 000001 with direction up
  - BLINK: 000000
  - OFF: 000000
- **On each step:**
  - FLOW_L: rotate left (100000→000001).
  - FLOW_R: rotate right (000001→100000).
  - PING_PONG: shift in the current direction. Direction reverses at 100000 and at 000001. The sequence is 1,2,4,8,16,32,16,8,4,2,1,2…, period 10 steps.
  - BLINK: invert all bits (000000↔111111).
  - OFF: no change; `led` stays 000000.
- **Speed press alone:** clears the counters, leaves `led` and the PING_PONG direction unchanged.
- **Simultaneous mode and speed presses in the same cycle:** both take effect. The mode advances, the speed increments, the entry pattern loads and the counters clear.
- **Press coinciding with a step:** the press wins. The step is discarded and the entry pattern or held pattern applies.

## Timing
- **Reset values:**
  - `led` = 000000, `mode` = 0, `speed` = 0.
  - All counters 0, PING_PONG direction up.
  - Synchronizer and stable key registers = 1 (released).
- **Reset mid-operation:** all state returns to the reset values asynchronously. Operation resumes from OFF on the first clock after deassertion.
- **Key latency:**
  - A pin low that stays clean at edge k is in sync stage 2 after 2 edges.
  - The stable level changes DEBOUNCE_CYC cycles later.
  - The press pulse is high in the following cycle.
  - `mode`/`speed`/`led` update on the clock edge ending the pulse cycle.
- **Glitches:** a level held for fewer than DEBOUNCE_CYC consecutive synced cycles is ignored.
- **Step timing:** the first step after an entry pattern or speed change occurs exactly one step period after the update edge. `led` changes on the step edge, with no further pipeline.
- **Key hold:** holding a key produces exactly one press event. Repeat requires a release of at least DEBOUNCE_CYC cycles.

## Test plan
Bench parameters: CLK_DIV_BASE=4, DEBOUNCE_CYC=8.
- Reset, keys held high for 200 cycles → `led`=000000, `mode`=0, `speed`=0, no output change.
- `key_mode_n` toggles every 3 cycles for 30 cycles, then held low → exactly one advance: `mode`=1, `led`=000001. Toggling with a period under 8 cycles alone → no advance.
- FLOW_L, speed 0 → `led` steps every 16 cycles through 000001, 000010, 000100, 001000, 010000, 100000, 000001.
- Three speed presses → `speed`=3, steps every 4 cycles, pattern continues without reload. Fourth press → `speed`=0.
- Advance to PING_PONG → the 12 steps read 2,4,8,16,32,16,8,4,2,1,2,4. Next mode press → BLINK, `led` alternates 000000/111111.
- In FLOW_R with speed 1, press both keys in the same cycle → `mode`=3, `speed`=2, `led`=000001, first step 8 cycles later. Assert `reset_n` mid-step → all outputs 0 immediately.
